bitbrick_fusion_accum: RTL and testbench

Downstream consumer of the per-bitbrick shift stage. Takes the NUM_BB signed, already-shifted 16-bit partial products of one fusion unit per beat, reduces them through a 2-stage registered adder tree, and accumulates beat sums into a saturating signed accumulator until a beat tagged last. Emits one dot-product result per last beat on a valid/ready output.

---
 rtl/bitbrick_fusion_accum.sv | 100 ++++++++++
 tb/tb_bitbrick_fusion_accum.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bitbrick_fusion_accum.sv
// bitbrick_fusion_accum: reduces masked bitbrick partial products into a saturating dot-product accumulator
module bitbrick_fusion_accum #(
  parameter int NUM_BB = 16,
  parameter int PW = 16,
  parameter int ACC_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic [NUM_BB-1:0]      in_mask,
  input  logic [NUM_BB*PW-1:0]   in_products,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       out_data,
  output logic                   out_ovf
);
  localparam int G = NUM_BB / 4;
  localparam int GW = PW + 2;
  localparam int BW = GW + $clog2(G);
  localparam int EW = (ACC_W > BW ? ACC_W : BW) + 1;
  localparam logic signed [EW-1:0] MAXV = (EW'(1) << (ACC_W - 1)) - EW'(1);
  localparam logic signed [EW-1:0] MINV = -MAXV - EW'(1);
  logic stall;
  logic signed [GW-1:0] grp [G];
  logic signed [GW-1:0] s1_sum [G];
  logic s1_valid, s1_last;
  logic signed [BW-1:0] beat, s2_sum;
  logic s2_valid, s2_last;
  logic signed [ACC_W-1:0] acc, sat_val;
  logic signed [EW-1:0] tmp;
  logic sticky, sat_hi, sat_lo;
  assign stall = out_valid && !out_ready;
  assign in_ready = !stall;
  // mask, sign-extend and add products in groups of four
  always_comb begin
    for (int g = 0; g < G; g++) begin
      grp[g] = '0;
      for (int k = 0; k < 4; k++)
        grp[g] = grp[g] + (in_mask[4*g+k] ? GW'($signed(in_products[(4*g+k)*PW +: PW])) : GW'(0));
    end
  end
  // stage 1: register group sums
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last <= 1'b0;
      s1_sum <= '{default: '0};
    end else if (!stall) begin
      s1_valid <= in_valid;
      s1_last <= in_last;
      s1_sum <= grp;
    end
  end
  // fold group sums into one beat sum
  always_comb begin
    beat = '0;
    for (int g = 0; g < G; g++) beat = beat + BW'(s1_sum[g]);
  end
  // stage 2: register beat sum
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_last <= 1'b0;
      s2_sum <= '0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
      s2_last <= s1_last;
      s2_sum <= beat;
    end
  end
  // widened add of the beat onto the running sum, clamped to the accumulator range
  always_comb begin
    tmp = EW'(acc) + EW'(s2_sum);
    sat_hi = tmp > MAXV;
    sat_lo = tmp < MINV;
    sat_val = sat_hi ? ACC_W'(MAXV) : sat_lo ? ACC_W'(MINV) : tmp[ACC_W-1:0];
  end
  // stage 3: accumulate, emit on last beat and restart clean in the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      sticky <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_ovf <= 1'b0;
    end else if (!stall) begin
      out_valid <= s2_valid && s2_last;
      if (s2_valid) begin
        acc <= s2_last ? '0 : sat_val;
        sticky <= s2_last ? 1'b0 : (sticky | sat_hi | sat_lo);
      end
      if (s2_valid && s2_last) begin
        out_data <= sat_val;
        out_ovf <= sticky | sat_hi | sat_lo;
      end
    end
  end
endmodule

// File: tb/tb_bitbrick_fusion_accum.sv
// tb_bitbrick_fusion_accum: directed checks of reduction, accumulation, handshake and saturation
module tb_bitbrick_fusion_accum;
  logic clk = 0, rst = 1, in_valid = 0, in_last = 0, out_ready = 1;
  logic [15:0] in_mask = '0;
  logic [255:0] in_products = '0;
  logic in_ready, out_valid, out_ovf, in_ready20, out_valid20, out_ovf20;
  logic [31:0] out_data;
  logic [19:0] out_data20;
  int total = 0, bad = 0;
  logic [31:0] q32[$];
  logic q32o[$];
  logic [19:0] q20[$];
  logic q20o[$];

  always #5 clk = ~clk;

  bitbrick_fusion_accum dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_mask(in_mask), .in_products(in_products), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf));

  bitbrick_fusion_accum #(.ACC_W(20)) dut20 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready20), .in_last(in_last),
    .in_mask(in_mask), .in_products(in_products), .out_valid(out_valid20), .out_ready(out_ready),
    .out_data(out_data20), .out_ovf(out_ovf20));

  always @(negedge clk) begin
    if (out_valid && out_ready) begin q32.push_back(out_data); q32o.push_back(out_ovf); end
    if (out_valid20 && out_ready) begin q20.push_back(out_data20); q20o.push_back(out_ovf20); end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_q;
    q32.delete(); q32o.delete(); q20.delete(); q20o.delete();
  endtask

  task automatic send(input logic [255:0] p, input logic [15:0] m, input logic l);
    logic ok;
    ok = 0;
    in_valid = 1; in_products = p; in_mask = m; in_last = l;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL send_timeout got=in_ready_low exp=accept"); end
    @(posedge clk);
    #1;
    in_valid = 0; in_last = 0;
  endtask

  task automatic check_q32(input string name, input int idx, input logic [31:0] exp, input logic eo);
    logic [31:0] v;
    logic o;
    v = (q32.size() > idx) ? q32[idx] : 'x;
    o = (q32o.size() > idx) ? q32o[idx] : 1'bx;
    total++;
    if (v !== exp || o !== eo) begin
      bad++;
      $display("FAIL %s got=%0d/%b exp=%0d/%b", name, $signed(v), o, $signed(exp), eo);
    end
  endtask

  task automatic test_reset;
    rst = 1; idle(2);
    rst = 0; #1;
    total += 4;
    if (out_valid !== 0) begin bad++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    if (out_data !== 0) begin bad++; $display("FAIL rst_data got=%0h exp=0", out_data); end
    if (out_ovf !== 0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", out_ovf); end
    if (in_ready !== 1) begin bad++; $display("FAIL rst_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_single;
    clear_q(); out_ready = 1;
    send({16{16'h0001}}, 16'hFFFF, 1);
    idle(1);
    total++;
    if (out_valid !== 0) begin bad++; $display("FAIL lat_early got=%b exp=0", out_valid); end
    idle(1);
    total += 3;
    if (out_valid !== 1) begin bad++; $display("FAIL lat_valid got=%b exp=1", out_valid); end
    if (out_data !== 32'd16) begin bad++; $display("FAIL single_data got=%0d exp=16", out_data); end
    if (out_ovf !== 0) begin bad++; $display("FAIL single_ovf got=%b exp=0", out_ovf); end
    idle(3);
    total++;
    if (q32.size() != 1) begin bad++; $display("FAIL single_count got=%0d exp=1", q32.size()); end
  endtask

  task automatic test_sign;
    clear_q();
    send({8{16'h0004, 16'hFFF0}}, 16'hFFFF, 1);
    idle(5);
    check_q32("sign", 0, 32'hFFFFFFA0, 0);
  endtask

  task automatic test_multi;
    clear_q();
    send({16{16'h0100}}, 16'hFFFF, 0);
    send({16{16'h0100}}, 16'h00FF, 0);
    send({16{16'h0100}}, 16'hFFFF, 1);
    idle(6);
    total++;
    if (q32.size() != 1) begin bad++; $display("FAIL multi_count got=%0d exp=1", q32.size()); end
    check_q32("multi", 0, 32'h2800, 0);
  endtask

  task automatic test_mask_zero;
    clear_q();
    send({16{16'h1234}}, 16'h0000, 1);
    idle(5);
    total++;
    if (q32.size() != 1) begin bad++; $display("FAIL maskz_count got=%0d exp=1", q32.size()); end
    check_q32("maskz", 0, 32'd0, 0);
  endtask

  task automatic test_back_to_back;
    clear_q();
    send(256'd1, 16'hFFFF, 1);
    send(256'd2, 16'hFFFF, 1);
    idle(1);
    send(256'd3, 16'h0001, 1);
    idle(6);
    total++;
    if (q32.size() != 3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", q32.size()); end
    check_q32("b2b0", 0, 32'd1, 0);
    check_q32("b2b1", 1, 32'd2, 0);
    check_q32("b2b2", 2, 32'd3, 0);
  endtask

  task automatic test_backpressure;
    clear_q(); out_ready = 0;
    send(256'd3, 16'hFFFF, 1);
    send(256'd5, 16'hFFFF, 1);
    send(256'd7, 16'hFFFF, 1);
    repeat (4) @(negedge clk);
    total += 3;
    if (in_ready !== 0) begin bad++; $display("FAIL bp_ready got=%b exp=0", in_ready); end
    if (out_valid !== 1) begin bad++; $display("FAIL bp_valid got=%b exp=1", out_valid); end
    if (out_data !== 32'd3) begin bad++; $display("FAIL bp_hold got=%0d exp=3", out_data); end
    @(posedge clk); #1;
    out_ready = 1;
    idle(6);
    total++;
    if (q32.size() != 3) begin bad++; $display("FAIL bp_count got=%0d exp=3", q32.size()); end
    check_q32("bp0", 0, 32'd3, 0);
    check_q32("bp1", 1, 32'd5, 0);
    check_q32("bp2", 2, 32'd7, 0);
  endtask

  task automatic test_saturation;
    logic [19:0] v;
    clear_q();
    send({16{16'h7FFF}}, 16'hFFFF, 0);
    send({16{16'h7FFF}}, 16'hFFFF, 0);
    send({16{16'h7FFF}}, 16'hFFFF, 1);
    send(256'd1, 16'hFFFF, 1);
    idle(6);
    total++;
    if (q20.size() != 2) begin bad++; $display("FAIL sat_count got=%0d exp=2", q20.size()); end
    v = (q20.size() > 0) ? q20[0] : 'x;
    total++;
    if (v !== 20'h7FFFF || q20o[0] !== 1) begin bad++; $display("FAIL sat_value got=%0h/%b exp=7ffff/1", v, q20o[0]); end
    v = (q20.size() > 1) ? q20[1] : 'x;
    total++;
    if (v !== 20'd1 || q20o[1] !== 0) begin bad++; $display("FAIL sat_clean got=%0h/%b exp=1/0", v, q20o[1]); end
    check_q32("wide_nosat", 0, 32'd1572816, 0);
    check_q32("wide_next", 1, 32'd1, 0);
  endtask

  task automatic test_reset_mid;
    clear_q();
    send(256'd100, 16'hFFFF, 0);
    send(256'd100, 16'hFFFF, 0);
    rst = 1; idle(1);
    rst = 0;
    send(256'd3, 16'hFFFF, 1);
    idle(6);
    total++;
    if (q32.size() != 1) begin bad++; $display("FAIL rstmid_count got=%0d exp=1", q32.size()); end
    check_q32("rstmid", 0, 32'd3, 0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_sign();
    test_multi();
    test_mask_zero();
    test_back_to_back();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
